// File: rtl/lsu_dq_pkg.sv
// Shared LSU dispatch-queue constants and Gray-code helpers.
// Used by the dispatch side and the LSU issue side.
package lsu_dq_pkg;

  localparam int LSU_DQ_DEPTH = 16;
  localparam int LSU_INSTR_W  = 113;
  localparam int LSU_PTR_W    = 5;

  typedef logic [LSU_PTR_W-1:0] lsuPtr_t;

  function automatic lsuPtr_t bin2gray(
    input lsuPtr_t b
  );
    return b ^ (b >> 1);
  endfunction

  function automatic lsuPtr_t gray2bin(
    input lsuPtr_t g
  );
    lsuPtr_t b;
    b = g;
    for (int i = LSU_PTR_W - 2; i >= 0; i--)
      b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

endpackage

// File: rtl/lsu_gray_sync.sv
// Multi-flop synchronizer for a Gray-coded pointer crossing clocks.
// Ports: clk, rst (async high), d (async in), q (last stage).
module lsu_gray_sync #(
  parameter int WIDTH  = 5,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stg [STAGES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++)
        stg[i] <= '0;
    end else begin
      stg[0] <= d;
      for (int i = 1; i < STAGES; i++)
        stg[i] <= stg[i-1];
    end
  end

  assign q = stg[STAGES-1];

endmodule

// File: rtl/lsu_dispatch_queue.sv
// Write side of the dispatch->LSU async queue: slot array, Gray
// write pointer, synchronized read pointer and registered full.
// Ports: clk, rst (async high), i_Valid_1/i_Instruction_113 in,
// o_Ready_1, o_Full_1, o_InstructionToLSUIssue_1808 (flat slots),
// o_LsuGray_5 (wr ptr), i_LsuRdGray_5 (async rd ptr).
// Option: LSU_DQ_OCCUPANCY_EN adds o_LSUCount_5 occupancy output.
module lsu_dispatch_queue
  import lsu_dq_pkg::*;
#(
  parameter int DEPTH       = LSU_DQ_DEPTH,
  parameter int INSTR_W     = LSU_INSTR_W,
  parameter int SYNC_STAGES = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int PW = AW + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_Valid_1,
  input  logic [INSTR_W-1:0]       i_Instruction_113,
  output logic                     o_Ready_1,
  output logic [DEPTH*INSTR_W-1:0] o_InstructionToLSUIssue_1808,
  output logic [PW-1:0]            o_LsuGray_5,
  input  logic [PW-1:0]            i_LsuRdGray_5,
`ifdef LSU_DQ_OCCUPANCY_EN
  output logic [PW-1:0]            o_LSUCount_5,
`endif
  output logic                     o_Full_1
);

  logic [INSTR_W-1:0] slots [DEPTH];
  logic [PW-1:0]      wrBin;
  logic [PW-1:0]      wrBinNxt;
  logic [PW-1:0]      wrGrayInt;
  logic [PW-1:0]      wrGray;
  logic [PW-1:0]      rdSync;
  logic [PW-1:0]      rdFull;
  logic               fullQ;
  logic               enq;

  lsu_gray_sync #(
    .WIDTH  (PW),
    .STAGES (SYNC_STAGES)
  ) uRdSync (
    .clk (clk),
    .rst (rst),
    .d   (i_LsuRdGray_5),
    .q   (rdSync)
  );

  assign enq       = i_Valid_1 & ~fullQ;
  assign wrBinNxt  = wrBin + {{AW{1'b0}}, enq};
  // Gray of the pointer as it will be after this edge, so the
  // full flag lands in the very cycle after the filling write.
  assign wrGrayInt = bin2gray(wrBinNxt);
  // Read pointer one lap behind: top two Gray bits inverted.
  assign rdFull    = {~rdSync[PW-1:PW-2], rdSync[PW-3:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrBin  <= '0;
      wrGray <= '0;
      fullQ  <= 1'b0;
      for (int k = 0; k < DEPTH; k++)
        slots[k] <= '0;
    end else begin
      // Published pointer trails the slot write by one cycle.
      wrGray <= bin2gray(wrBin);
      fullQ  <= (wrGrayInt == rdFull);
      if (enq) begin
        slots[wrBin[AW-1:0]] <= i_Instruction_113;
        wrBin                <= wrBinNxt;
      end
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : gFlat
    assign o_InstructionToLSUIssue_1808[k*INSTR_W +: INSTR_W] = slots[k];
  end

  assign o_LsuGray_5 = wrGray;
  assign o_Full_1    = fullQ;
  assign o_Ready_1   = ~fullQ;

`ifdef LSU_DQ_OCCUPANCY_EN
  logic [PW-1:0] cntQ;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cntQ <= '0;
    else
      cntQ <= wrBin - gray2bin(rdSync);
  end

  assign o_LSUCount_5 = cntQ;
`endif

endmodule

// File: tb/tb_lsu_dispatch_queue.sv
// Directed bench for lsu_dispatch_queue with a data scoreboard.
// Build with LSU_DQ_OCCUPANCY_EN to also cover the count output.
module tb_lsu_dispatch_queue;

  localparam int DEPTH = 16;
  localparam int W     = 113;
  localparam int PW    = 5;

  logic              clk;
  logic              rst;
  logic              valid;
  logic [W-1:0]      instr;
  logic              ready;
  logic [DEPTH*W-1:0] flat;
  logic [PW-1:0]     wrGray;
  logic [PW-1:0]     rdGray;
  logic              full;
`ifdef LSU_DQ_OCCUPANCY_EN
  logic [PW-1:0]     cnt;
`endif

  int nTests = 0;
  int nFail  = 0;
  logic [W-1:0] sbq [$];

  lsu_dispatch_queue #(
    .DEPTH       (DEPTH),
    .INSTR_W     (W),
    .SYNC_STAGES (2)
  ) dut (
    .clk                          (clk),
    .rst                          (rst),
    .i_Valid_1                    (valid),
    .i_Instruction_113            (instr),
    .o_Ready_1                    (ready),
    .o_InstructionToLSUIssue_1808 (flat),
    .o_LsuGray_5                  (wrGray),
    .i_LsuRdGray_5                (rdGray),
`ifdef LSU_DQ_OCCUPANCY_EN
    .o_LSUCount_5                 (cnt),
`endif
    .o_Full_1                     (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [PW-1:0] tbGray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PW-1:0] tbBin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  function automatic logic [W-1:0] slot(input int k);
    return flat[k*W +: W];
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    nTests++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst    = 1'b1;
    valid  = 1'b0;
    rdGray = '0;
    step();
    rst = 1'b0;
    sbq.delete();
  endtask

  logic [W-1:0]  expD;
  logic [PW-1:0] rdBin;
  logic [PW-1:0] prevGray;
  int sent, got, cyc;
  bit acc;

  initial begin
    rst    = 1'b1;
    valid  = 1'b0;
    instr  = '0;
    rdGray = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", ready, 1);
    chk("rst_full", full, 0);
    chk("rst_gray", wrGray, 0);
    chk("rst_slots_zero", (flat == '0), 1);
    rst = 1'b0;

    // three writes, pointer published one cycle after each
    for (int i = 0; i < 3; i++) begin
      valid = 1'b1;
      instr = W'(i + 1);
      sbq.push_back(W'(i + 1));
      step();
      chk("seq_slot", slot(i), sbq.pop_front());
      chk("seq_gray_lag", wrGray, tbGray(PW'(i)));
    end
    valid = 1'b0;
    step();
    chk("seq_gray_last", wrGray, 5'b00010);

    // fill to sixteen, then try a seventeenth
    doReset();
    for (int i = 0; i < 16; i++) begin
      valid = 1'b1;
      instr = W'(32'h100 + i);
      sbq.push_back(W'(32'h100 + i));
      if (i == 15) begin
        chk("fill15_full", full, 0);
        chk("fill15_ready", ready, 1);
      end
      step();
    end
    chk("fill_full", full, 1);
    chk("fill_ready", ready, 0);
    instr = W'(32'hDEAD);
    step();
    valid = 1'b0;
    chk("overfill_full", full, 1);
    chk("fill_gray", wrGray, 5'b11000);
    for (int k = 0; k < 16; k++)
      chk("fill_slot", slot(k), sbq.pop_front());

    // one read through the synchronizer frees a slot
    rdGray = 5'b00001;
    step();
    chk("rdlat_c1", ready, 0);
    step();
    chk("rdlat_c2", ready, 0);
    step();
    chk("rdlat_c3", ready, 1);
    valid = 1'b1;
    instr = W'(32'hBEEF);
    step();
    valid = 1'b0;
    chk("refill_slot0", slot(0), W'(32'hBEEF));
    chk("refill_full", full, 1);

    // streaming against a slow reader, across the pointer wrap
    doReset();
    rdBin    = '0;
    prevGray = '0;
    sent = 0;
    got  = 0;
    cyc  = 0;
    while (got < 40 && cyc < 3000) begin
      valid = (sent < 40);
      instr = W'(32'h1000 + sent);
      acc   = valid && ready;
      if (acc) sbq.push_back(instr);
      if (cyc % 3 == 0 && tbBin(wrGray) != rdBin) begin
        expD = (sbq.size() > 0) ? sbq.pop_front() : 'x;
        chk("stream_data", slot(int'(rdBin[3:0])), expD);
        got++;
        rdBin  = rdBin + 1'b1;
        rdGray = tbGray(rdBin);
      end
      step();
      cyc++;
      if (acc) sent++;
      chk("stream_gray_1bit", ($countones(wrGray ^ prevGray) <= 1), 1);
      prevGray = wrGray;
    end
    valid = 1'b0;
    chk("stream_all_read", got, 40);
    chk("stream_wrapped_gray", wrGray, tbGray(5'd8));

    // reset in the middle of traffic
    doReset();
    for (int i = 0; i < 5; i++) begin
      valid = 1'b1;
      instr = W'(32'h50 + i);
      step();
    end
    valid = 1'b0;
    step();
    chk("pre_rst_gray", wrGray, tbGray(5'd5));
    rst = 1'b1;
    #1;
    chk("midrst_gray", wrGray, 0);
    chk("midrst_full", full, 0);
    chk("midrst_ready", ready, 1);
    chk("midrst_slots", (flat == '0), 1);
    @(posedge clk);
    #1;
    rst   = 1'b0;
    valid = 1'b1;
    instr = W'(32'h77);
    step();
    valid = 1'b0;
    chk("postrst_slot0", slot(0), W'(32'h77));
    chk("postrst_slot1", slot(1), 0);

`ifdef LSU_DQ_OCCUPANCY_EN
    doReset();
    chk("cnt_rst", cnt, 0);
    for (int i = 0; i < 7; i++) begin
      valid = 1'b1;
      instr = W'(i);
      step();
    end
    valid  = 1'b0;
    rdGray = 5'b00011;
    repeat (4) step();
    chk("cnt_five", cnt, 5);
    valid  = 1'b1;
    instr  = W'(32'h99);
    rdGray = 5'b00010;
    step();
    valid = 1'b0;
    repeat (4) step();
    chk("cnt_balanced", cnt, 5);
`endif

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
